// File: rtl/riscv_dmem_responder_pkg.sv
// Package for the data-memory responder: FSM state type and funct3
// legality helper shared by the top and the lane-alignment block.
`include "riscv_configs.v"

package riscv_dmem_responder_pkg;

    typedef enum logic [1:0] {
        S_IDLE = `DMEM_ST_IDLE,
        S_WAIT = `DMEM_ST_WAIT,
        S_RESP = `DMEM_ST_RESP
    } state_e;

    localparam int unsigned WAIT_CYCLES_MAX = 15;

    // Loads and stores accept different funct3 sets.
    function automatic logic f3_legal(input logic wr_en, input logic [2:0] f3);
        if (wr_en) return f3 inside {`F3_SB, `F3_SH, `F3_SW};
        else       return f3 inside {`F3_LB, `F3_LH, `F3_LW, `F3_LBU, `F3_LHU};
    endfunction

endpackage

// File: rtl/riscv_dmem_responder_if.sv
// Data-memory request/response bundle.
// Handshake: the initiator raises i_dmem_req with the access fields; the
// responder samples them once while idle and later pulses o_dmem_ready for
// exactly one cycle, with o_dmem_rd_data / o_dmem_err valid only in that cycle.
//   master : initiator side (drives i_dmem_*, receives o_dmem_*)
//   slave  : responder side (receives i_dmem_*, drives o_dmem_*)
`include "riscv_configs.v"

interface riscv_dmem_responder_if;
    logic              i_dmem_req;
    logic              i_dmem_wr_en;
    logic [2:0]        i_dmem_funct3;
    logic [`XLEN-1:0]  i_dmem_addr;
    logic [`XLEN-1:0]  i_dmem_wr_data;
    logic              o_dmem_ready;
    logic [`XLEN-1:0]  o_dmem_rd_data;
    logic              o_dmem_err;

    modport master (
        output i_dmem_req, i_dmem_wr_en, i_dmem_funct3, i_dmem_addr, i_dmem_wr_data,
        input  o_dmem_ready, o_dmem_rd_data, o_dmem_err
    );

    modport slave (
        input  i_dmem_req, i_dmem_wr_en, i_dmem_funct3, i_dmem_addr, i_dmem_wr_data,
        output o_dmem_ready, o_dmem_rd_data, o_dmem_err
    );
endinterface

// File: rtl/riscv_configs.v
// Shared RISC-V configuration constants.
//   XLEN          : integer register / bus width.
//   F3_*          : RV32I load/store funct3 encodings.
//   DMEM_ST_*     : state codes of the data-memory responder FSM.
// Optional feature macro used elsewhere (not defined here):
//   RISCV_DMEM_MISALIGN_CHECK_EN
`ifndef RISCV_CONFIGS_V
`define RISCV_CONFIGS_V

`define XLEN 32

`define F3_LB  3'b000
`define F3_LH  3'b001
`define F3_LW  3'b010
`define F3_LBU 3'b100
`define F3_LHU 3'b101
`define F3_SB  3'b000
`define F3_SH  3'b001
`define F3_SW  3'b010

`define DMEM_ST_IDLE 2'd0
`define DMEM_ST_WAIT 2'd1
`define DMEM_ST_RESP 2'd2

`endif

// File: rtl/riscv_dmem_responder_align.sv
// riscv_dmem_align: combinational lane logic for one access.
// Ports:
//   i_wr_en, i_funct3 : access kind and size/sign
//   i_addr_lo         : byte offset within the word
//   i_wr_data         : right-aligned store data
//   i_mem_word        : addressed memory word (for loads)
//   o_byte_en         : byte write enables (zero for loads and illegal accesses)
//   o_wr_word         : store data replicated into every lane
//   o_rd_data         : extended load result (zero for stores / errors)
//   o_err             : illegal funct3 or (optionally) misaligned access
// Optional feature: RISCV_DMEM_MISALIGN_CHECK_EN enables misalignment errors.
`include "riscv_configs.v"

module riscv_dmem_align
    import riscv_dmem_responder_pkg::*;
(
    input  logic              i_wr_en,
    input  logic [2:0]        i_funct3,
    input  logic [1:0]        i_addr_lo,
    input  logic [`XLEN-1:0]  i_wr_data,
    input  logic [`XLEN-1:0]  i_mem_word,
    output logic [3:0]        o_byte_en,
    output logic [`XLEN-1:0]  o_wr_word,
    output logic [`XLEN-1:0]  o_rd_data,
    output logic              o_err
);
    logic              misalign;
    logic [`XLEN-1:0]  byte_shift;
    logic [`XLEN-1:0]  half_shift;
    logic [7:0]        lane_b;
    logic [15:0]       lane_h;

`ifdef RISCV_DMEM_MISALIGN_CHECK_EN
    logic is_half;
    logic is_word;
    assign is_half  = (i_funct3[1:0] == 2'b01);
    assign is_word  = (i_funct3[1:0] == 2'b10);
    assign misalign = (is_half && i_addr_lo[0]) || (is_word && (i_addr_lo != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    // Half-word lane uses addr[1] only, so addr[0] is ignored for halves.
    assign byte_shift = i_mem_word >> {i_addr_lo, 3'b000};
    assign half_shift = i_mem_word >> {i_addr_lo[1], 4'b0000};
    assign lane_b     = byte_shift[7:0];
    assign lane_h     = half_shift[15:0];
    assign o_err      = !f3_legal(i_wr_en, i_funct3) || misalign;

    always_comb begin
        o_byte_en = 4'b0000;
        o_wr_word = '0;
        o_rd_data = '0;
        if (!o_err) begin
            if (i_wr_en) begin
                case (i_funct3)
                    `F3_SB: begin
                        o_byte_en = 4'b0001 << i_addr_lo;
                        o_wr_word = {4{i_wr_data[7:0]}};
                    end
                    `F3_SH: begin
                        o_byte_en = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                        o_wr_word = {2{i_wr_data[15:0]}};
                    end
                    `F3_SW: begin
                        o_byte_en = 4'b1111;
                        o_wr_word = i_wr_data;
                    end
                    default: ;
                endcase
            end else begin
                case (i_funct3)
                    `F3_LB:  o_rd_data = {{24{lane_b[7]}}, lane_b};
                    `F3_LH:  o_rd_data = {{16{lane_h[15]}}, lane_h};
                    `F3_LW:  o_rd_data = i_mem_word;
                    `F3_LBU: o_rd_data = {24'd0, lane_b};
                    `F3_LHU: o_rd_data = {16'd0, lane_h};
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: rtl/riscv_dmem_responder.sv
// riscv_dmem_responder: single-port data memory answering RV32I loads and
// stores with a fixed, parameterised number of wait states.
// Ports:
//   i_clk, i_rstn : clock, asynchronous active-low reset
//   dmem          : request/response bundle (slave side)
//   o_dbg_state   : current FSM state code
// Parameters: MEM_DEPTH (words, power of two), WAIT_CYCLES (0..15).
// Optional feature: RISCV_DMEM_MISALIGN_CHECK_EN (see riscv_dmem_align).
`include "riscv_configs.v"

module riscv_dmem_responder
    import riscv_dmem_responder_pkg::*;
#(
    parameter int unsigned MEM_DEPTH   = 1024,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic                   i_clk,
    input  logic                   i_rstn,
    riscv_dmem_responder_if.slave  dmem,
    output logic [1:0]             o_dbg_state
);
    localparam int unsigned AW        = $clog2(MEM_DEPTH);
    localparam logic [3:0]  WAIT_LAST = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    state_e            state_q, state_d;
    logic [3:0]        wait_cnt_q, wait_cnt_d;
    logic              req_wr_en_q, req_wr_en_d;
    logic [2:0]        req_funct3_q, req_funct3_d;
    logic [`XLEN-1:0]  req_addr_q, req_addr_d;
    logic [`XLEN-1:0]  req_wr_data_q, req_wr_data_d;

    logic [`XLEN-1:0]  mem [MEM_DEPTH];
    logic [AW-1:0]     word_idx;
    logic [`XLEN-1:0]  mem_word;
    logic [3:0]        byte_en;
    logic [`XLEN-1:0]  wr_word;
    logic [`XLEN-1:0]  rd_data;
    logic              align_err;
    logic              in_resp;
    logic              unused_addr_hi;

    // Upper address bits are dropped, so accesses wrap modulo the array size.
    assign word_idx       = req_addr_q[AW+1:2];
    assign unused_addr_hi = ^req_addr_q[`XLEN-1:AW+2];
    assign mem_word       = mem[word_idx];
    assign in_resp        = (state_q == S_RESP);

    riscv_dmem_align u_align (
        .i_wr_en    (req_wr_en_q),
        .i_funct3   (req_funct3_q),
        .i_addr_lo  (req_addr_q[1:0]),
        .i_wr_data  (req_wr_data_q),
        .i_mem_word (mem_word),
        .o_byte_en  (byte_en),
        .o_wr_word  (wr_word),
        .o_rd_data  (rd_data),
        .o_err      (align_err)
    );

    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        req_wr_en_d   = req_wr_en_q;
        req_funct3_d  = req_funct3_q;
        req_addr_d    = req_addr_q;
        req_wr_data_d = req_wr_data_q;
        case (state_q)
            S_IDLE: begin
                if (dmem.i_dmem_req) begin
                    req_wr_en_d   = dmem.i_dmem_wr_en;
                    req_funct3_d  = dmem.i_dmem_funct3;
                    req_addr_d    = dmem.i_dmem_addr;
                    req_wr_data_d = dmem.i_dmem_wr_data;
                    wait_cnt_d    = 4'd0;
                    state_d       = (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
                end
            end
            S_WAIT: begin
                if (wait_cnt_q == WAIT_LAST) state_d = S_RESP;
                else                         wait_cnt_d = wait_cnt_q + 4'd1;
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q       <= S_IDLE;
            wait_cnt_q    <= 4'd0;
            req_wr_en_q   <= 1'b0;
            req_funct3_q  <= 3'd0;
            req_addr_q    <= '0;
            req_wr_data_q <= '0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            req_wr_en_q   <= req_wr_en_d;
            req_funct3_q  <= req_funct3_d;
            req_addr_q    <= req_addr_d;
            req_wr_data_q <= req_wr_data_d;
        end
    end

    // Array is never reset. Reset drops the FSM to IDLE, so an in-flight
    // store cannot reach this write. byte_en is zero for loads and errors.
    always_ff @(posedge i_clk) begin
        if (in_resp) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) mem[word_idx][8*b +: 8] <= wr_word[8*b +: 8];
            end
        end
    end

    assign dmem.o_dmem_ready   = in_resp;
    assign dmem.o_dmem_err     = in_resp && align_err;
    assign dmem.o_dmem_rd_data = in_resp ? rd_data : '0;
    assign o_dbg_state         = state_q;
endmodule

// File: doc/riscv_dmem_responder.md
RISCV_DMEM_RESPONDER -- requirements
Module: riscv_dmem_responder

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 1024: number of 32-bit words held; power of two.
REQ-002 SHALL have parameter WAIT_CYCLES, default 0: extra wait states inserted before each response; range 0..15.
REQ-003 SHALL have port i_clk, input, 1: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port i_rstn, input, 1: asynchronous active-low reset.
REQ-005 SHALL have port i_dmem_req, input, 1: the initiator has an access pending.
REQ-006 SHALL have port i_dmem_wr_en, input, 1: 1 = store, 0 = load.
REQ-007 SHALL have port i_dmem_funct3, input, 3: access size and sign, using RV32I load/store funct3 encoding.
REQ-008 SHALL have port i_dmem_addr, input, `XLEN: byte address.
REQ-009 SHALL have port i_dmem_wr_data, input, `XLEN: store data, right-aligned.
REQ-010 SHALL have port o_dmem_ready, output, 1: one-cycle response pulse.
REQ-011 SHALL have port o_dmem_rd_data, output, `XLEN: load result; valid only while o_dmem_ready=1.
REQ-012 SHALL have port o_dmem_err, output, 1: access rejected; valid only while o_dmem_ready=1.

Function
REQ-013 SHALL implement an FSM with states IDLE, WAIT and RESP.
REQ-014 SHALL, in IDLE with i_dmem_req=1, capture wr_en, funct3, addr and wr_data at that edge, clear the wait counter, and go to WAIT if WAIT_CYCLES>0, else to RESP.
REQ-015 SHALL stay in WAIT for exactly WAIT_CYCLES cycles (counter 0..WAIT_CYCLES-1), then go to RESP.
REQ-016 SHALL assert o_dmem_ready for exactly the one cycle spent in RESP, and return to IDLE unconditionally.
REQ-017 SHALL put the response in cycle N+1+WAIT_CYCLES, where N is the capture cycle; the minimum request spacing is WAIT_CYCLES+2 cycles.
REQ-018 SHALL ignore i_dmem_req in WAIT and RESP; input changes after capture have no effect.
REQ-019 SHALL use word index addr[log2(MEM_DEPTH)+1:2]; higher address bits are ignored, so accesses wrap modulo 4*MEM_DEPTH bytes.
REQ-020 SHALL perform stores on the rising edge that ends RESP:
- SB (000) writes the byte lane addr[1:0].
- SH (001) writes the half-word lane addr[1].
- SW (010) writes the whole word.
REQ-021 SHALL return loads in RESP from the captured word:
- LB (000) and LH (001) are sign-extended.
- LBU (100) and LHU (101) are zero-extended.
- LW (010) returns the word.
Lanes are selected as in REQ-020.
REQ-022 SHALL treat any funct3 outside the encodings in REQ-020 (stores) and REQ-021 (loads) as illegal: o_dmem_err=1, o_dmem_rd_data=0, no memory write.
REQ-023 SHALL drive o_dmem_rd_data=0 for stores and whenever o_dmem_ready=0.

Reset
REQ-024 SHALL, on i_rstn low at any time, force state=IDLE, wait counter=0, o_dmem_ready=0, o_dmem_err=0, o_dmem_rd_data=0, and clear the captured request registers.
REQ-025 SHALL discard any in-flight access on reset, so a store pending in WAIT or RESP never writes memory.
REQ-026 SHALL NOT reset memory array contents.

Configuration
REQ-027 SHALL, when RISCV_DMEM_MISALIGN_CHECK_EN is defined, flag half-word accesses with addr[0]=1 and word accesses with addr[1:0]!=0 as errors: o_dmem_err=1, rd_data=0, no write.
REQ-028 SHALL, when RISCV_DMEM_MISALIGN_CHECK_EN is undefined, never raise misalignment errors: half-word accesses ignore addr[0] and word accesses ignore addr[1:0].

Structure
REQ-029 SHALL take funct3 encodings (LB/LH/LW/LBU/LHU/SB/SH/SW) and FSM state codes as `define constants from the shared riscv_configs.v.
REQ-030 SHALL place lane select, byte-enable generation and sign/zero extension in one combinational sub-module, riscv_dmem_align; the FSM and memory array stay in the top.

Verification
REQ-031 SHALL cover: WAIT_CYCLES=0; SW 0xDEADBEEF to 0x10, then LW 0x10 -> ready in the cycle after each capture, rd_data=0xDEADBEEF, err=0.
REQ-032 SHALL cover: SB 0x80 to 0x13, then LB 0x13 and LBU 0x13 -> 0xFFFFFF80 and 0x00000080; LW 0x10 -> 0x80ADBEEF.
REQ-033 SHALL cover: WAIT_CYCLES=3; LW captured at cycle 10 -> ready high only in cycle 14; req held high throughout -> next capture at cycle 15.
REQ-034 SHALL cover: macro defined; LW 0x12 and SH 0x11 -> err=1, rd_data=0, memory unchanged. Macro undefined; LW 0x12 -> returns the word at 0x10, err=0.
REQ-035 SHALL cover: funct3=011 load -> err=1, rd_data=0. MEM_DEPTH=1024; SW to 0x1010 -> the word at 0x10 is updated (wrap).
REQ-036 SHALL cover: WAIT_CYCLES=3; SW 0x12345678 to 0x20 with i_rstn pulsed low mid-WAIT -> ready never asserts, LW 0x20 returns the prior contents.
